// File: rtl/sort_stream_checker_if.sv
// sort_stream_checker_if: Avalon-ST bundle carrying the sorted packet stream into the checker
interface sort_stream_checker_if #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic              valid;
    logic              ready;
    modport master (output data, startofpacket, endofpacket, valid, input ready);
    modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/sort_stream_checker.sv
// sort_stream_checker: Avalon-ST sink checking framing, length and non-decreasing order per packet
module sort_stream_checker #(
    parameter int DWIDTH      = 16,
    parameter int MAX_PKT_LEN = 13,
    parameter int CNTW        = 16,
    parameter int LENW        = $clog2(MAX_PKT_LEN) + 2
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    sort_stream_checker_if.slave  snk,
    input  logic                  ready_en_i,
    output logic                  pkt_done_o,
    output logic                  pkt_ok_o,
    output logic [LENW-1:0]       pkt_len_o,
    output logic                  err_order_o,
    output logic                  err_len_o,
    output logic                  err_framing_o,
    output logic                  stray_o,
    output logic [CNTW-1:0]       pkt_cnt_o,
    output logic [CNTW-1:0]       err_cnt_o
);
    typedef enum logic [1:0] {IDLE, IN_PKT, REPORT} state_t;
    state_t            state_q, state_d;
    logic [LENW-1:0]   len_q, len_d, len_inc, rlen_q, rlen_d, rep_len;
    logic [DWIDTH-1:0] prev_q, prev_d;
    logic [CNTW-1:0]   pcnt_q, pcnt_d, ecnt_q, ecnt_d;
    logic              ord_q, ord_d, lerr_q, lerr_d, ret_q, ret_d, pend_q, pend_d;
    logic              done_q, done_d, ok_q, ok_d, stray_q, stray_d;
    logic              rord_q, rord_d, rlerr_q, rlerr_d, rfrm_q, rfrm_d;
    logic              acc, rep, rep_ord, rep_lerr, rep_frm;

    assign snk.ready     = srst_i && ready_en_i && (state_q != REPORT);
    assign pkt_done_o    = done_q;
    assign pkt_ok_o      = ok_q;
    assign pkt_len_o     = rlen_q;
    assign err_order_o   = rord_q;
    assign err_len_o     = rlerr_q;
    assign err_framing_o = rfrm_q;
    assign stray_o       = stray_q;
    assign pkt_cnt_o     = pcnt_q;
    assign err_cnt_o     = ecnt_q;

    always_comb begin
        acc      = snk.valid && snk.ready;
        len_inc  = &len_q ? len_q : len_q + LENW'(1);
        state_d  = state_q;
        len_d    = len_q;
        prev_d   = prev_q;
        ord_d    = ord_q;
        lerr_d   = lerr_q;
        ret_d    = ret_q;
        pend_d   = pend_q;
        stray_d  = 1'b0;
        rep      = 1'b0;
        rep_len  = len_q;
        rep_ord  = ord_q;
        rep_lerr = lerr_q;
        rep_frm  = 1'b0;
        case (state_q)
            IDLE: if (acc) begin
                if (snk.startofpacket) begin
                    len_d    = LENW'(1);
                    prev_d   = snk.data;
                    ord_d    = 1'b0;
                    lerr_d   = 1'b0;
                    ret_d    = 1'b0;
                    rep      = snk.endofpacket;
                    rep_len  = LENW'(1);
                    rep_ord  = 1'b0;
                    rep_lerr = 1'b0;
                    state_d  = snk.endofpacket ? REPORT : IN_PKT;
                end else begin
                    stray_d = 1'b1;
                end
            end
            IN_PKT: if (acc) begin
                if (snk.startofpacket) begin
                    // report the aborted packet now; the sop word seeds the next one
                    rep     = 1'b1;
                    rep_frm = 1'b1;
                    len_d   = LENW'(1);
                    prev_d  = snk.data;
                    ord_d   = 1'b0;
                    lerr_d  = 1'b0;
                    ret_d   = !snk.endofpacket;
                    pend_d  = snk.endofpacket;
                    state_d = REPORT;
                end else begin
                    len_d    = len_inc;
                    prev_d   = snk.data;
                    ord_d    = ord_q | (snk.data < prev_q);
                    lerr_d   = lerr_q | (len_inc > LENW'(MAX_PKT_LEN));
                    ret_d    = 1'b0;
                    rep      = snk.endofpacket;
                    rep_len  = len_d;
                    rep_ord  = ord_d;
                    rep_lerr = lerr_d;
                    state_d  = snk.endofpacket ? REPORT : IN_PKT;
                end
            end
            default: begin
                rep     = pend_q;
                pend_d  = 1'b0;
                state_d = pend_q ? REPORT : (ret_q ? IN_PKT : IDLE);
            end
        endcase
        done_d  = rep;
        ok_d    = rep ? !(rep_ord || rep_lerr || rep_frm) : ok_q;
        rlen_d  = rep ? rep_len : rlen_q;
        rord_d  = rep ? rep_ord : rord_q;
        rlerr_d = rep ? rep_lerr : rlerr_q;
        rfrm_d  = rep ? rep_frm : rfrm_q;
        pcnt_d  = (rep && !(&pcnt_q)) ? pcnt_q + CNTW'(1) : pcnt_q;
        ecnt_d  = ((stray_d || (rep && !ok_d)) && !(&ecnt_q)) ? ecnt_q + CNTW'(1) : ecnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            prev_q  <= '0;
            ord_q   <= 1'b0;
            lerr_q  <= 1'b0;
            ret_q   <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            rlen_q  <= '0;
            rord_q  <= 1'b0;
            rlerr_q <= 1'b0;
            rfrm_q  <= 1'b0;
            stray_q <= 1'b0;
            pcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            prev_q  <= prev_d;
            ord_q   <= ord_d;
            lerr_q  <= lerr_d;
            ret_q   <= ret_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            rlen_q  <= rlen_d;
            rord_q  <= rord_d;
            rlerr_q <= rlerr_d;
            rfrm_q  <= rfrm_d;
            stray_q <= stray_d;
            pcnt_q  <= pcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end
endmodule

// File: tb/tb_sort_stream_checker.sv
// tb_sort_stream_checker: scoreboard bench with a packet-level reference model for sort_stream_checker
module tb_sort_stream_checker;
    localparam int DW   = 16;
    localparam int MAXL = 13;
    localparam int CW   = 16;
    localparam int LW   = $clog2(MAXL) + 2;
    localparam int LSAT = (1 << LW) - 1;

    typedef struct {
        bit stray;
        int cyc;
        int len;
        bit ok;
        bit ord;
        bit lerr;
        bit frm;
        int pcnt;
        int ecnt;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b0;
    logic          ready_en_i = 1'b1;
    logic          pkt_done_o, pkt_ok_o, err_order_o, err_len_o, err_framing_o, stray_o;
    logic [LW-1:0] pkt_len_o;
    logic [CW-1:0] pkt_cnt_o, err_cnt_o;

    sort_stream_checker_if #(.DWIDTH(DW)) sif ();

    sort_stream_checker #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL), .CNTW(CW)) dut (
        .clk_i         (clk_i),
        .srst_i        (srst_i),
        .snk           (sif),
        .ready_en_i    (ready_en_i),
        .pkt_done_o    (pkt_done_o),
        .pkt_ok_o      (pkt_ok_o),
        .pkt_len_o     (pkt_len_o),
        .err_order_o   (err_order_o),
        .err_len_o     (err_len_o),
        .err_framing_o (err_framing_o),
        .stray_o       (stray_o),
        .pkt_cnt_o     (pkt_cnt_o),
        .err_cnt_o     (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   cur[$];
    bit   in_pkt = 0;
    int   pcnt = 0;
    int   ecnt = 0;
    bit   stall = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Packet-level model: judge the collected word list as a whole
    function automatic void finalize(input bit frm, input int c);
        bit ord = 0;
        bit lerr;
        bit ok;
        int len;
        for (int i = 1; i < cur.size(); i++) if (cur[i] < cur[i-1]) ord = 1;
        lerr = cur.size() > MAXL;
        len  = cur.size() > LSAT ? LSAT : cur.size();
        ok   = !(ord || lerr || frm);
        pcnt++;
        if (!ok) ecnt++;
        q.push_back('{0, c, len, ok, ord, lerr, frm, pcnt, ecnt});
        in_pkt = 0;
    endfunction

    function automatic void model_accept(input int d, input bit s, input bit e);
        int c = cyc + 1;
        if (!in_pkt && !s) begin
            ecnt++;
            q.push_back('{1, c, 0, 0, 0, 0, 0, pcnt, ecnt});
            return;
        end
        if (in_pkt && s) begin
            finalize(1, c);
            c++;
        end
        if (s) begin
            cur.delete();
            in_pkt = 1;
        end
        cur.push_back(d);
        if (e) finalize(0, c);
    endfunction

    task automatic send(input int d, input bit s, input bit e);
        bit acc = 0;
        int n = 0;
        sif.data          = DW'(d);
        sif.startofpacket = s;
        sif.endofpacket   = e;
        sif.valid         = 1'b1;
        while (!acc && n < 64) begin
            ready_en_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            acc = sif.ready;
            if (!ready_en_i) chk("ready_gated", {31'd0, sif.ready}, 0);
            if (acc) model_accept(d, s, e);
            @(negedge clk_i);
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        sif.valid  = 1'b0;
        ready_en_i = 1'b1;
    endtask

    task automatic idle();
        sif.valid         = 1'b0;
        sif.startofpacket = 1'($urandom_range(0, 1));
        sif.data          = DW'($urandom_range(0, 65535));
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        srst_i    = 1'b0;
        sif.valid = 1'b0;
        cur.delete();
        in_pkt = 0;
        pcnt   = 0;
        ecnt   = 0;
        #1;
        chk("ready_in_reset", {31'd0, sif.ready}, 0);
        @(negedge clk_i);
        srst_i = 1'b1;
        #1;
        chk("rst_pkt_cnt", 32'(pkt_cnt_o), 0);
        chk("rst_err_cnt", 32'(err_cnt_o), 0);
        chk("rst_pkt_len", 32'(pkt_len_o), 0);
        chk("rst_flags", {26'd0, pkt_done_o, pkt_ok_o, err_order_o, err_len_o, err_framing_o, stray_o}, 0);
        @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (pkt_done_o || stray_o) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {30'd0, pkt_done_o, stray_o}, 0);
            end else begin
                e = q.pop_front();
                chk("stray", {31'd0, stray_o}, {31'd0, e.stray});
                chk("pkt_done", {31'd0, pkt_done_o}, {31'd0, !e.stray});
                chk("latency_cycle", cyc, e.cyc);
                chk("pkt_cnt", 32'(pkt_cnt_o), e.pcnt);
                chk("err_cnt", 32'(err_cnt_o), e.ecnt);
                if (!e.stray) begin
                    chk("pkt_len", 32'(pkt_len_o), e.len);
                    chk("pkt_ok", {31'd0, pkt_ok_o}, {31'd0, e.ok});
                    chk("err_order", {31'd0, err_order_o}, {31'd0, e.ord});
                    chk("err_len", {31'd0, err_len_o}, {31'd0, e.lerr});
                    chk("err_framing", {31'd0, err_framing_o}, {31'd0, e.frm});
                end
            end
        end
    end

    initial begin
        int n, v, k;
        bit sorted, abort;
        int p1[5] = '{1, 2, 2, 5, 9};
        int p2[4] = '{3, 7, 4, 8};
        sif.valid = 1'b0;
        sif.data = '0;
        sif.startofpacket = 1'b0;
        sif.endofpacket = 1'b0;
        @(negedge clk_i);
        do_reset();
        for (int i = 0; i < 5; i++) send(p1[i], i == 0, i == 4);
        idle();
        for (int i = 0; i < 4; i++) send(p2[i], i == 0, i == 3);
        for (int i = 0; i < 14; i++) send(i, i == 0, i == 13);
        send(1, 1, 0);
        send(2, 0, 0);
        send(5, 1, 0);
        send(6, 0, 1);
        send('h00AA, 0, 0);
        send('h0010, 1, 1);
        send(4, 1, 0);
        send(3, 1, 1);
        repeat (3) idle();
        do_reset();
        stall = 1;
        for (int i = 0; i < 5; i++) send(p1[i], i == 0, i == 4);
        stall = 0;
        send(1, 1, 0);
        send(2, 0, 0);
        do_reset();
        stall = 1;
        repeat (40) begin
            n      = $urandom_range(1, 16);
            v      = $urandom_range(0, 1000);
            sorted = 1'($urandom_range(0, 1));
            abort  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 6) == 0) send($urandom_range(0, 65535), 0, 1'($urandom_range(0, 1)));
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 3);
                v = sorted ? v + k : $urandom_range(0, 65535);
                send(v, i == 0, (i == n - 1) && !abort);
                if ($urandom_range(0, 4) == 0) idle();
            end
        end
        send(7, 1, 1);
        repeat (4) idle();
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
